// File: rtl/micro_op_scheduler_pkg.sv
// Shared types and constants for the micro-op scheduler that fronts the
// 8-bit microprogrammed processor.
package micro_op_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_START,
      ST_WAIT_DONE,
      ST_RESPOND,
      ST_RECOVER
   } sched_state_t;

   localparam int RECOVER_CYCLES = 2;
   localparam int OPCODE_W       = 4;
   localparam int DATA_W         = 8;
   localparam int UADDR_W        = 8;
   localparam int RESP_ID_W      = 1;

endpackage

// File: rtl/micro_op_scheduler_if.sv
// Bundle of request, response and processor-pin signals around the scheduler.
// slave = scheduler side, master = requesters/consumer/processor side.
interface micro_op_scheduler_if;
   import micro_op_sched_pkg::*;

   logic                 req0_valid;
   logic                 req0_ready;
   logic [OPCODE_W-1:0]  req0_opcode;
   logic [DATA_W-1:0]    req0_a;
   logic [DATA_W-1:0]    req0_b;

   logic                 req1_valid;
   logic                 req1_ready;
   logic [OPCODE_W-1:0]  req1_opcode;
   logic [DATA_W-1:0]    req1_a;
   logic [DATA_W-1:0]    req1_b;

   logic                 resp_valid;
   logic                 resp_ready;
   logic [RESP_ID_W-1:0] resp_id;
   logic [DATA_W-1:0]    resp_data;
   logic                 resp_err;

   logic [OPCODE_W-1:0]  cpu_opcode;
   logic [DATA_W-1:0]    cpu_data_a;
   logic [DATA_W-1:0]    cpu_data_b;
   logic                 cpu_go_bar;
   logic                 cpu_reset;
   logic [UADDR_W-1:0]   cpu_microaddress;
   logic [DATA_W-1:0]    cpu_data_out;

   logic                 busy;

   modport slave (
      input  req0_valid, req0_opcode, req0_a, req0_b,
      input  req1_valid, req1_opcode, req1_a, req1_b,
      input  resp_ready, cpu_microaddress, cpu_data_out,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_data, resp_err,
      output cpu_opcode, cpu_data_a, cpu_data_b, cpu_go_bar, cpu_reset,
      output busy
   );

   modport master (
      output req0_valid, req0_opcode, req0_a, req0_b,
      output req1_valid, req1_opcode, req1_a, req1_b,
      output resp_ready, cpu_microaddress, cpu_data_out,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_data, resp_err,
      input  cpu_opcode, cpu_data_a, cpu_data_b, cpu_go_bar, cpu_reset,
      input  busy
   );

endinterface

// File: rtl/micro_op_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arbiter_2
   import micro_op_sched_pkg::*;
(
   input  logic [1:0] req_valid,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt    = 2'b00;
      gnt[0] = req_valid[0] & (~req_valid[1] | last_gnt);
      gnt[1] = req_valid[1] & (~req_valid[0] | ~last_gnt);
   end

endmodule

// File: rtl/micro_op_scheduler.sv
// Shares one microprogrammed processor between two requesters: arbitrates,
// launches the microprogram, waits for completion and recovers a hung core.
//
// state         | meaning
// --------------+------------------------------------------------------
// ST_IDLE       | ready for a request, processor parked
// ST_ISSUE      | GO_BAR low for one cycle, timeout counter loaded
// ST_WAIT_START | waiting for the microaddress to leave IDLE_UADDR
// ST_WAIT_DONE  | waiting for the microaddress to return to IDLE_UADDR
// ST_RECOVER    | processor held in reset after a timeout
// ST_RESPOND    | response presented until the consumer takes it
module micro_op_scheduler
   import micro_op_sched_pkg::*;
#(
   parameter logic [UADDR_W-1:0] IDLE_UADDR = 8'h00,
   parameter int unsigned        TIMEOUT    = 255
) (
   input  logic                system_clk,
   input  logic                reset_bar,
   micro_op_scheduler_if.slave bus
);

   localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);
   localparam logic [7:0] REC_LOAD = 8'(RECOVER_CYCLES - 1);

   sched_state_t        state, state_nxt;
   logic [7:0]          cnt_q, cnt_nxt;
   logic [1:0]          gnt;
   logic                last_gnt;
   logic                accept;
   logic                resp_id_q;
   logic [DATA_W-1:0]   resp_data_q;
   logic                resp_err_q;
   logic [OPCODE_W-1:0] opcode_q;
   logic [DATA_W-1:0]   data_a_q, data_b_q;
   logic                go_bar_q, cpu_reset_q;

   rr_arbiter_2 u_arb (
      .req_valid ({bus.req1_valid, bus.req0_valid}),
      .last_gnt  (last_gnt),
      .gnt       (gnt)
   );

   assign accept = (state == ST_IDLE) && (gnt != 2'b00);

   // One counter serves both the timeout and the recovery hold: the two
   // windows never overlap.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_q;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            cnt_nxt   = TMO_LOAD;
            state_nxt = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (cnt_q == 8'd0) begin
               state_nxt = ST_RECOVER;
               cnt_nxt   = REC_LOAD;
            end else begin
               cnt_nxt = cnt_q - 8'd1;
               if (bus.cpu_microaddress != IDLE_UADDR) state_nxt = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (cnt_q == 8'd0) begin
               state_nxt = ST_RECOVER;
               cnt_nxt   = REC_LOAD;
            end else begin
               cnt_nxt = cnt_q - 8'd1;
               if (bus.cpu_microaddress == IDLE_UADDR) state_nxt = ST_RESPOND;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == 8'd0) state_nxt = ST_RESPOND;
            else               cnt_nxt   = cnt_q - 8'd1;
         end
         ST_RESPOND: begin
            if (bus.resp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge system_clk or negedge reset_bar) begin
      if (!reset_bar) begin
         state       <= ST_IDLE;
         cnt_q       <= 8'd0;
         last_gnt    <= 1'b1;
         resp_id_q   <= 1'b0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
         opcode_q    <= '0;
         data_a_q    <= '0;
         data_b_q    <= '0;
         go_bar_q    <= 1'b1;
         cpu_reset_q <= 1'b1;
      end else begin
         state       <= state_nxt;
         cnt_q       <= cnt_nxt;
         go_bar_q    <= (state_nxt != ST_ISSUE);
         cpu_reset_q <= (state_nxt == ST_RECOVER);
         if (accept) begin
            resp_id_q <= gnt[1];
            last_gnt  <= gnt[1];
            opcode_q  <= gnt[1] ? bus.req1_opcode : bus.req0_opcode;
            data_a_q  <= gnt[1] ? bus.req1_a      : bus.req0_a;
            data_b_q  <= gnt[1] ? bus.req1_b      : bus.req0_b;
         end
         if (state == ST_WAIT_DONE && state_nxt == ST_RESPOND) begin
            resp_data_q <= bus.cpu_data_out;
            resp_err_q  <= 1'b0;
         end
         if (state != ST_RECOVER && state_nxt == ST_RECOVER) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b1;
         end
      end
   end

   assign bus.req0_ready = (state == ST_IDLE) & gnt[0];
   assign bus.req1_ready = (state == ST_IDLE) & gnt[1];
   assign bus.resp_valid = (state == ST_RESPOND);
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.cpu_opcode = opcode_q;
   assign bus.cpu_data_a = data_a_q;
   assign bus.cpu_data_b = data_b_q;
   assign bus.cpu_go_bar = go_bar_q;
   assign bus.cpu_reset  = cpu_reset_q;
   assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_micro_op_scheduler.sv
// Scoreboard bench for micro_op_scheduler with a small behavioural processor
// model that can run normally, hang mid-program or never start.
module tb_micro_op_scheduler;

   localparam int TMO = 20;
   localparam int N_CYC = 6;

   typedef struct {
      bit         id;
      logic [7:0] data;
      bit         err;
   } exp_t;

   logic clk = 1'b0;
   logic reset_bar;
   int   n_tests = 0;
   int   n_fail = 0;
   int   go_lows = 0;
   int   rst_highs = 0;
   int   mode = 0;
   exp_t q[$];
   exp_t mon_e;
   logic go_seen;
   logic [7:0] uaddr;

   micro_op_scheduler_if bus ();

   micro_op_scheduler #(.IDLE_UADDR(8'h00), .TIMEOUT(TMO)) dut (
      .system_clk (clk),
      .reset_bar  (reset_bar),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'h1:    return a + b;
         4'h2:    return a - b;
         4'h3:    return a & b;
         default: return a ^ b;
      endcase
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Processor model: one cycle after sampling GO_BAR low it leaves the idle
   // microaddress; mode 0 returns after N_CYC cycles, 1 hangs, 2 never starts.
   always @(posedge clk) begin
      if (bus.cpu_reset) begin
         go_seen <= 1'b0;
         uaddr   <= 8'h00;
      end else begin
         go_seen <= ~bus.cpu_go_bar;
         if (go_seen && mode != 2)
            uaddr <= 8'h01;
         else if (uaddr != 8'h00 && mode == 0)
            uaddr <= (uaddr == 8'(N_CYC)) ? 8'h00 : uaddr + 8'h01;
      end
   end

   assign bus.cpu_microaddress = uaddr;
   assign bus.cpu_data_out     = alu(bus.cpu_opcode, bus.cpu_data_a, bus.cpu_data_b);

   always @(negedge clk) begin
      if (!bus.cpu_go_bar) go_lows++;
      if (bus.cpu_reset)   rst_highs++;
      if (reset_bar && bus.resp_valid && bus.resp_ready) begin
         if (q.size() == 0) begin
            chk("unexp_resp", 1, 0);
         end else begin
            mon_e = q.pop_front();
            chk("resp_id",   int'(bus.resp_id),   int'(mon_e.id));
            chk("resp_data", int'(bus.resp_data), int'(mon_e.data));
            chk("resp_err",  int'(bus.resp_err),  int'(mon_e.err));
         end
      end
   end

   task automatic do_reset();
      reset_bar = 1'b0;
      q.delete();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #1;
      chk("rst_busy",   int'(bus.busy),       0);
      chk("rst_go_bar", int'(bus.cpu_go_bar), 1);
      chk("rst_cpurst", int'(bus.cpu_reset),  1);
      chk("rst_rvalid", int'(bus.resp_valid), 0);
      chk("rst_rdata",  int'(bus.resp_data),  0);
      chk("rst_ready0", int'(bus.req0_ready), 0);
      chk("rst_opcode", int'(bus.cpu_opcode), 0);
      repeat (2) @(posedge clk);
      #1 reset_bar = 1'b1;
      @(negedge clk);
      chk("rst_hold_cpurst", int'(bus.cpu_reset), 1);
      @(posedge clk);
      #1 chk("rst_rel_cpurst", int'(bus.cpu_reset), 0);
   endtask

   task automatic wait_accept(input bit id);
      int  n;
      bit  hs;
      n  = 0;
      hs = 1'b0;
      while (!hs && n < 300) begin
         @(negedge clk);
         n++;
         hs = id ? (bus.req1_valid & bus.req1_ready) : (bus.req0_valid & bus.req0_ready);
      end
      chk("accept_seen", int'(hs), 1);
   endtask

   task automatic send(input bit id, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input bit err);
      exp_t e;
      e.id   = id;
      e.data = err ? 8'h00 : alu(op, a, b);
      e.err  = err;
      q.push_back(e);
      if (id) begin
         bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
      end else begin
         bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
      end
      wait_accept(id);
      @(posedge clk);
      #1;
      if (id) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
   endtask

   task automatic resp_latency(input string tag, input int exp);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!bus.resp_valid && n < 200);
      chk(tag, n, exp);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("drain", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   g0, r0, n, acc;
      exp_t e;
      reset_bar = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_opcode = '0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_valid = 1'b0; bus.req1_opcode = '0; bus.req1_a = '0; bus.req1_b = '0;
      bus.resp_ready = 1'b1;
      #2;
      do_reset();

      // single request, latency and GO_BAR pulse count
      g0 = go_lows;
      send(1'b0, 4'h1, 8'h05, 8'h03, 1'b0);
      resp_latency("single_lat", 9);
      chk("single_go_pulses", go_lows - g0, 1);
      drain();

      // ties alternate, first tie after reset goes to requester 0
      do_reset();
      bus.req0_opcode = 4'h2; bus.req0_a = 8'h40; bus.req0_b = 8'h11;
      bus.req1_opcode = 4'h4; bus.req1_a = 8'hA5; bus.req1_b = 8'h0F;
      for (int i = 0; i < 4; i++) begin
         e.id   = (i % 2 == 1);
         e.data = e.id ? alu(4'h4, 8'hA5, 8'h0F) : alu(4'h2, 8'h40, 8'h11);
         e.err  = 1'b0;
         q.push_back(e);
      end
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      acc = 0;
      n   = 0;
      while (acc < 4 && n < 400) begin
         @(negedge clk);
         n++;
         if ((bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready)) acc++;
      end
      chk("tie_accepts", acc, 4);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      drain();

      // back-pressure holds the response and blocks new work
      bus.resp_ready = 1'b0;
      send(1'b0, 4'h2, 8'h09, 8'h04, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.resp_valid && n < 100);
      chk("bp_valid", int'(bus.resp_valid), 1);
      @(posedge clk);
      #1;
      e.id = 1'b1; e.data = alu(4'h3, 8'hF0, 8'h3C); e.err = 1'b0;
      q.push_back(e);
      bus.req1_opcode = 4'h3; bus.req1_a = 8'hF0; bus.req1_b = 8'h3C; bus.req1_valid = 1'b1;
      g0 = go_lows;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", int'(bus.resp_valid), 1);
         chk("bp_hold_id",    int'(bus.resp_id),    int'(q[0].id));
         chk("bp_hold_data",  int'(bus.resp_data),  int'(q[0].data));
         chk("bp_hold_err",   int'(bus.resp_err),   int'(q[0].err));
         chk("bp_ready1",     int'(bus.req1_ready), 0);
         chk("bp_ready0",     int'(bus.req0_ready), 0);
      end
      chk("bp_go_pulses", go_lows - g0, 0);
      @(posedge clk);
      #1 bus.resp_ready = 1'b1;
      wait_accept(1'b1);
      @(posedge clk);
      #1 bus.req1_valid = 1'b0;
      drain();

      // hung processor: timeout through WAIT_DONE, then normal service
      mode = 1;
      r0 = rst_highs;
      send(1'b0, 4'h1, 8'h11, 8'h22, 1'b1);
      resp_latency("hung_lat", TMO + 3);
      drain();
      chk("hung_cpu_reset_cycles", rst_highs - r0, 2);
      mode = 0;
      send(1'b1, 4'h4, 8'h0F, 8'h33, 1'b0);
      drain();

      // processor never starts: timeout through WAIT_START
      mode = 2;
      r0 = rst_highs;
      send(1'b1, 4'h2, 8'h07, 8'h01, 1'b1);
      resp_latency("stuck_lat", TMO + 3);
      drain();
      chk("stuck_cpu_reset_cycles", rst_highs - r0, 2);
      mode = 0;

      // reset while waiting for completion
      send(1'b1, 4'h1, 8'h20, 8'h02, 1'b0);
      repeat (5) @(posedge clk);
      #1 chk("mid_busy_before", int'(bus.busy), 1);
      do_reset();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.resp_valid) n++;
      end
      chk("mid_no_resp", n, 0);
      send(1'b0, 4'h3, 8'hCC, 8'hAA, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
